approx_series: RTL

APPROX_SERIES -- requirements
Module: approx_series

---
 rtl/approx_series.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/approx_series.sv
// approx_series: iterative truncated geometric series 1/(1-x) or 1/(1+x).
// Sums N terms of x^n (mode 0) or (-x)^n (mode 1) in signed fixed point.
// Optional feature: define APPROX_SAT_EN to clamp the result to DW+1 bits
// and flag the clamp on ovf_o; otherwise the result wraps and ovf_o is 0.
module approx_series #(
    parameter int unsigned DW   = 16,
    parameter int unsigned FRAC = 12,
    parameter int unsigned NW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic signed [DW-1:0] x_i,
    input  logic [NW-1:0]        nIt_i,
    input  logic                 mode_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic signed [DW:0]   y_o,
    output logic                 ovf_o
);

    localparam int unsigned AW = 2 * DW + 2;
    localparam int unsigned PW = AW + DW;
    localparam logic signed [AW-1:0] ONE   = AW'(1) << FRAC;
    localparam logic signed [AW-1:0] Y_MAX = (AW'(1) << DW) - AW'(1);
    localparam logic signed [AW-1:0] Y_MIN = ~Y_MAX;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic signed [DW-1:0] x_q;
    logic                 mode_q;
    logic [NW-1:0]        n_q;
    logic [NW-1:0]        cnt_q;
    logic signed [AW-1:0] term_q;
    logic signed [AW-1:0] acc_q;

    logic                 start_acc_c;
    logic                 calc_run_c;
    logic signed [PW-1:0] prod_c;
    logic signed [AW-1:0] term_nxt_c;

    // Start is honoured outside CALC; a CALC cycle progresses unless aborted
    assign start_acc_c = start_i && (state_q != CALC);
    assign calc_run_c  = (state_q == CALC) && !abort_i;

    // Next series term: floor(term*x / 2^FRAC), negated for the alternating series
    always_comb begin
        prod_c     = PW'(term_q) * PW'(x_q);
        term_nxt_c = AW'(prod_c >>> FRAC);
        if (mode_q) begin
            term_nxt_c = -term_nxt_c;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort beats completion, DONE lasts one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_acc_c) state_d = CALC;
            CALC: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (cnt_q >= n_q) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = start_acc_c ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy_o  = 1'b0;
        valid_o = 1'b0;
        unique case (state_q)
            CALC:    busy_o  = 1'b1;
            DONE:    valid_o = 1'b1;
            default: ;
        endcase
    end

    // Operand capture and series accumulation
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            mode_q <= 1'b0;
            n_q    <= '0;
            cnt_q  <= '0;
            term_q <= '0;
            acc_q  <= '0;
        end else if (start_acc_c) begin
            x_q    <= x_i;
            mode_q <= mode_i;
            n_q    <= (nIt_i == '0) ? NW'(1) : nIt_i;
            cnt_q  <= NW'(1);
            term_q <= ONE;
            acc_q  <= ONE;
        end else if (calc_run_c && (cnt_q < n_q)) begin
            term_q <= term_nxt_c;
            acc_q  <= acc_q + term_nxt_c;
            cnt_q  <= cnt_q + NW'(1);
        end
    end

`ifdef APPROX_SAT_EN
    // Result register with clamping to the DW+1 bit signed range
    always_ff @(posedge clk) begin
        if (rst) begin
            y_o   <= '0;
            ovf_o <= 1'b0;
        end else if (calc_run_c && (cnt_q >= n_q)) begin
            if (acc_q > Y_MAX) begin
                y_o   <= Y_MAX[DW:0];
                ovf_o <= 1'b1;
            end else if (acc_q < Y_MIN) begin
                y_o   <= Y_MIN[DW:0];
                ovf_o <= 1'b1;
            end else begin
                y_o   <= acc_q[DW:0];
                ovf_o <= 1'b0;
            end
        end
    end
`else
    // Result register with two's-complement wrap; no overflow reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            y_o <= '0;
        end else if (calc_run_c && (cnt_q >= n_q)) begin
            y_o <= acc_q[DW:0];
        end
    end

    assign ovf_o = 1'b0;
`endif

endmodule
